calc_operand_loader: RTL and testbench
======================================

Name: calc_operand_loader

Overview:
- Downstream stage of the controller's input-key decoder in the binary calculator.
- Once the decoder asserts `active`, this block collects operand A, operand B and the opcode.
  - mode=1: serially, bit by bit.
  - mode=0: in parallel, in one shot.
- It presents the collected set to the ALU with a valid/ready handshake.
- It counts completed transactions for debug.

Parameters:
- WIDTH, 8, operand width in bits.
- OP_W, 4, opcode width in bits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- active  input  1  decoder "command accepted" flag; level-sensitive enable.
- mode  input  1  decoder mode: 1 = serial load, 0 = parallel load.
- serialIn  input  1  serial data bit, MSB first.
- serialValid  input  1  serialIn is meaningful this cycle.
- parA  input  WIDTH  parallel operand A.
- parB  input  WIDTH  parallel operand B.
- parOp  input  OP_W  parallel opcode.
- aluReady  input  1  ALU accepts the operand set this cycle.
- aluValid  output  1  operand set on opA/opB/opSel is valid.
- opA  output  WIDTH  operand A to ALU.
- opB  output  WIDTH  operand B to ALU.
- opSel  output  OP_W  opcode to ALU.
- busy  output  1  high in any state other than IDLE.
- txCount  output  8  number of completed ALU handshakes, modulo 256.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - aluValid=0, busy=0.
  - opA=0, opB=0, opSel=0, txCount=0.
  - Bit counter=0, latched mode=0.
- States: IDLE, LOAD_A, LOAD_B, LOAD_OP, ISSUE.
- IDLE:
  - active=0: stay in IDLE.
  - active=1: latch mode into `modeQ`; later changes on `mode` are ignored until the next return to IDLE.
  - modeQ=0: the same edge captures parA/parB/parOp into opA/opB/opSel and goes to ISSUE. aluValid is high the next cycle (latency 1).
  - modeQ=1: go to LOAD_A with bit counter=0. No data is captured on the IDLE->LOAD_A edge.
- LOAD_A:
  - Each cycle with serialValid=1: opA <= {opA[WIDTH-2:0], serialIn} and counter increments.
  - When the WIDTH-th bit is shifted in: counter resets to 0 and state goes to LOAD_B.
  - Cycles with serialValid=0 are stalls; nothing changes.
- LOAD_B: identical to LOAD_A into opB, WIDTH bits, then LOAD_OP.
- LOAD_OP: identical into opSel, OP_W bits, then ISSUE.
- Serial latency: the first bit is taken one cycle after leaving IDLE. aluValid rises on the cycle after the last opcode bit.
- Counter: $clog2(WIDTH)+1 bits wide, so WIDTH=8 and OP_W up to 8 need no special case.
- ISSUE:
  - aluValid=1; opA/opB/opSel are held stable.
  - aluReady=1: handshake completes. aluValid drops next cycle, txCount increments (255 wraps to 0), state goes to IDLE.
  - aluReady may already be high on entry to ISSUE; the handshake then completes in the first ISSUE cycle.
- Abort:
  - active falling in LOAD_A/LOAD_B/LOAD_OP returns to IDLE on the next edge and clears the counter.
  - Partially shifted opA/opB/opSel keep whatever they hold; aluValid is never raised for the aborted frame.
  - active falling during ISSUE does NOT abort: the transaction is held until aluReady.
- Back-to-back: after ISSUE->IDLE, if active is still 1, a new frame starts from IDLE on the next edge. Minimum one IDLE cycle between frames.
- serialIn and serialValid are ignored outside the LOAD states. parA/parB/parOp are sampled only on the IDLE edge that starts a mode-0 frame.
- Reset asserted mid-frame forces the full reset state immediately, independent of clk.
- busy = (state != IDLE).

Decomposition:
- Shared package calc_ctrl_pkg:
  - Enum type loader_state_t {IDLE, LOAD_A, LOAD_B, LOAD_OP, ISSUE}.
  - Constants MODE_PARALLEL=0 and MODE_SERIAL=1, shared with the key decoder.
  - Default WIDTH/OP_W constants.
- One natural sub-module, serial_shift_reg:
  - Parameterised width, with enable, clear and a bit-count "full" flag.
  - Instantiated once for opA/opB/opSel with a select, or three times; the FSM stays in the top.

Test Plan:
- Parallel load: reset 13 ns then release; mode=0, active=1, parA=8'h3C, parB=8'h05, parOp=4'h2, aluReady=1 -> one cycle later aluValid=1 with opA=3C, opB=05, opSel=2; aluValid low the following cycle; txCount=1.
- Serial load: mode=1, active=1, serialValid=1 continuously, bit stream 1010_0101 / 0000_0011 / 0001, aluReady=1 -> aluValid rises 21 cycles after IDLE exit with opA=A5, opB=03, opSel=1; txCount=1.
- Serial stalls: same stream with serialValid=0 on every other cycle -> identical opA/opB/opSel; aluValid delayed by the number of stall cycles only.
- Backpressure: hold aluReady=0 for 5 cycles in ISSUE, toggling parA and dropping active -> aluValid stays 1 with outputs unchanged; handshake completes on the cycle aluReady=1; txCount increments exactly once.
- Abort: drop active after 3 bits of LOAD_B -> state IDLE next cycle, aluValid never asserted, txCount unchanged; the next serial frame loads correctly from bit 0.
- Wrap and reset: 256 back-to-back parallel frames -> txCount returns to 0; asserting reset asynchronously mid-LOAD_A -> all outputs 0 immediately, busy=0.

Source files
------------

// File: rtl/calc_ctrl_pkg.sv
// Shared definitions for the calculator controller: loader states, decoder modes, default widths.
package calc_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_OP_W  = 4;

  localparam logic MODE_PARALLEL = 1'b0;
  localparam logic MODE_SERIAL   = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    LOAD_OP = 3'd3,
    ISSUE   = 3'd4
  } loader_state_t;

endpackage

// File: rtl/serial_shift_reg.sv
// MSB-first shift register with parallel load, bit counter and last-bit flag.
module serial_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         bit_in,
  output logic [W-1:0] data,
  output logic         last_c
);

  localparam int unsigned CNT_W = $clog2(W) + 1;

  logic [CNT_W-1:0] cnt;

  // High while the next accepted bit completes the word.
  assign last_c = (cnt == CNT_W'(W - 1));

  // Data register: parallel load wins over shift; clear only touches the counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
      cnt  <= '0;
    end else begin
      if (load) begin
        data <= load_data;
      end else if (shift_en) begin
        data <= W'({data, bit_in});
      end
      if (clr || (shift_en && last_c)) begin
        cnt <= '0;
      end else if (shift_en) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/calc_operand_loader.sv
// Collects operand A, operand B and opcode (serial or parallel) and issues them to the ALU.
module calc_operand_loader
  import calc_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned OP_W  = DEF_OP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic             mode,
  input  logic             serialIn,
  input  logic             serialValid,
  input  logic [WIDTH-1:0] parA,
  input  logic [WIDTH-1:0] parB,
  input  logic [OP_W-1:0]  parOp,
  input  logic             aluReady,
  output logic             aluValid,
  output logic [WIDTH-1:0] opA,
  output logic [WIDTH-1:0] opB,
  output logic [OP_W-1:0]  opSel,
  output logic             busy,
  output logic [7:0]       txCount
);

  loader_state_t state, next_state;
  logic          modeQ;

  logic shift_a, shift_b, shift_op;
  logic par_load, cnt_clr, tx_done, mode_latch;
  logic last_a_c, last_b_c, last_op_c;
  logic serial_bit;

  // Shifting only ever happens in a frame started in serial mode.
  assign serial_bit = serialValid && (modeQ == MODE_SERIAL);

  // State register plus registered status outputs derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      modeQ    <= MODE_PARALLEL;
      aluValid <= 1'b0;
      busy     <= 1'b0;
      txCount  <= 8'd0;
    end else begin
      state    <= next_state;
      aluValid <= (next_state == ISSUE);
      busy     <= (next_state != IDLE);
      if (mode_latch) begin
        modeQ <= mode;
      end
      if (tx_done) begin
        txCount <= txCount + 8'd1;
      end
    end
  end

  // Next-state and datapath controls; abort in any LOAD state when active drops.
  always_comb begin
    next_state = state;
    shift_a    = 1'b0;
    shift_b    = 1'b0;
    shift_op   = 1'b0;
    par_load   = 1'b0;
    cnt_clr    = 1'b0;
    tx_done    = 1'b0;
    mode_latch = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (active) begin
          mode_latch = 1'b1;
          if (mode == MODE_SERIAL) begin
            next_state = LOAD_A;
          end else begin
            par_load   = 1'b1;
            next_state = ISSUE;
          end
        end
      end
      LOAD_A: begin
        if (!active) begin
          cnt_clr    = 1'b1;
          next_state = IDLE;
        end else if (serial_bit) begin
          shift_a = 1'b1;
          if (last_a_c) next_state = LOAD_B;
        end
      end
      LOAD_B: begin
        if (!active) begin
          cnt_clr    = 1'b1;
          next_state = IDLE;
        end else if (serial_bit) begin
          shift_b = 1'b1;
          if (last_b_c) next_state = LOAD_OP;
        end
      end
      LOAD_OP: begin
        if (!active) begin
          cnt_clr    = 1'b1;
          next_state = IDLE;
        end else if (serial_bit) begin
          shift_op = 1'b1;
          if (last_op_c) next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (aluReady) begin
          tx_done    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  serial_shift_reg #(.W(WIDTH)) u_sr_a (
    .clk       (clk),
    .reset     (reset),
    .clr       (cnt_clr),
    .load      (par_load),
    .load_data (parA),
    .shift_en  (shift_a),
    .bit_in    (serialIn),
    .data      (opA),
    .last_c    (last_a_c)
  );

  serial_shift_reg #(.W(WIDTH)) u_sr_b (
    .clk       (clk),
    .reset     (reset),
    .clr       (cnt_clr),
    .load      (par_load),
    .load_data (parB),
    .shift_en  (shift_b),
    .bit_in    (serialIn),
    .data      (opB),
    .last_c    (last_b_c)
  );

  serial_shift_reg #(.W(OP_W)) u_sr_op (
    .clk       (clk),
    .reset     (reset),
    .clr       (cnt_clr),
    .load      (par_load),
    .load_data (parOp),
    .shift_en  (shift_op),
    .bit_in    (serialIn),
    .data      (opSel),
    .last_c    (last_op_c)
  );

endmodule

// File: tb/tb_calc_operand_loader.sv
// Directed bench for calc_operand_loader: parallel, serial, stalls, backpressure, abort, wrap, async reset.
module tb_calc_operand_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       active, mode, serialIn, serialValid, aluReady;
  logic [7:0] parA, parB;
  logic [3:0] parOp;
  logic       aluValid, busy;
  logic [7:0] opA, opB, txCount;
  logic [3:0] opSel;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit seen_valid;
  int exp_tx;
  int start;

  calc_operand_loader #(.WIDTH(8), .OP_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .active      (active),
    .mode        (mode),
    .serialIn    (serialIn),
    .serialValid (serialValid),
    .parA        (parA),
    .parB        (parB),
    .parOp       (parOp),
    .aluReady    (aluReady),
    .aluValid    (aluValid),
    .opA         (opA),
    .opB         (opB),
    .opSel       (opSel),
    .busy        (busy),
    .txCount     (txCount)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (aluValid) seen_valid = 1'b1;
  endtask

  // Send the low n bits of v, MSB first, optionally with a stall cycle before each bit.
  task automatic send_bits(input logic [7:0] v, input int n, input bit stall);
    for (int i = n - 1; i >= 0; i--) begin
      if (stall) begin
        serialValid = 1'b0;
        serialIn    = ~v[i];
        tick();
      end
      serialValid = 1'b1;
      serialIn    = v[i];
      tick();
    end
    serialValid = 1'b0;
  endtask

  // Full serial frame with aluReady high; checks latency, payload and handshake.
  task automatic serial_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic [3:0] op, input bit stall, input int exp_lat);
    mode     = 1'b1;
    active   = 1'b1;
    aluReady = 1'b1;
    tick();
    start = cyc;
    mode  = 1'b0;
    check_eq({tag, "_busy_load"}, busy, 1);
    send_bits(a, 8, stall);
    send_bits(b, 8, stall);
    send_bits({4'h0, op}, 4, stall);
    active = 1'b0;
    check_eq({tag, "_valid"}, aluValid, 1);
    check_eq({tag, "_latency"}, cyc - start + 1, exp_lat);
    check_eq({tag, "_opA"}, opA, a);
    check_eq({tag, "_opB"}, opB, b);
    check_eq({tag, "_opSel"}, opSel, op);
    tick();
    exp_tx = (exp_tx + 1) % 256;
    check_eq({tag, "_valid_drop"}, aluValid, 0);
    check_eq({tag, "_idle"}, busy, 0);
    check_eq({tag, "_txcount"}, txCount, exp_tx);
  endtask

  initial begin
    reset = 1'b1; active = 1'b0; mode = 1'b0; serialIn = 1'b0; serialValid = 1'b0;
    parA = 8'h00; parB = 8'h00; parOp = 4'h0; aluReady = 1'b0; exp_tx = 0;
    #13;
    reset = 1'b0;
    check_eq("rst_valid", aluValid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_opA", opA, 0);
    check_eq("rst_opB", opB, 0);
    check_eq("rst_opSel", opSel, 0);
    check_eq("rst_tx", txCount, 0);

    // Parallel load, latency 1.
    mode = 1'b0; active = 1'b1; parA = 8'h3C; parB = 8'h05; parOp = 4'h2; aluReady = 1'b1;
    tick();
    active = 1'b0;
    check_eq("par_valid", aluValid, 1);
    check_eq("par_opA", opA, 8'h3C);
    check_eq("par_opB", opB, 8'h05);
    check_eq("par_opSel", opSel, 4'h2);
    check_eq("par_busy", busy, 1);
    tick();
    exp_tx = 1;
    check_eq("par_valid_drop", aluValid, 0);
    check_eq("par_tx", txCount, exp_tx);
    tick();

    // Serial, continuous and with a stall before every bit.
    serial_frame("ser", 8'hA5, 8'h03, 4'h1, 1'b0, 21);
    tick();
    serial_frame("stall", 8'hA5, 8'h03, 4'h1, 1'b1, 41);
    tick();

    // Backpressure: held in ISSUE while parA toggles and active drops.
    mode = 1'b0; active = 1'b1; parA = 8'h81; parB = 8'h42; parOp = 4'hF; aluReady = 1'b0;
    tick();
    active = 1'b0;
    check_eq("bp_valid0", aluValid, 1);
    for (int i = 0; i < 5; i++) begin
      parA = ~parA;
      tick();
      check_eq("bp_valid_hold", aluValid, 1);
      check_eq("bp_opA_hold", opA, 8'h81);
      check_eq("bp_tx_hold", txCount, exp_tx);
    end
    aluReady = 1'b1;
    tick();
    exp_tx = exp_tx + 1;
    check_eq("bp_valid_drop", aluValid, 0);
    check_eq("bp_tx", txCount, exp_tx);
    check_eq("bp_opSel", opSel, 4'hF);
    tick();
    check_eq("bp_tx_once", txCount, exp_tx);

    // Abort after 3 bits of LOAD_B; opB was 8'h42, so partial shift of 101 gives 8'h15.
    seen_valid = 1'b0;
    mode = 1'b1; active = 1'b1;
    tick();
    send_bits(8'h77, 8, 1'b0);
    send_bits(8'h05, 3, 1'b0);
    active = 1'b0;
    tick();
    check_eq("abort_busy", busy, 0);
    check_eq("abort_no_valid", seen_valid, 0);
    check_eq("abort_tx", txCount, exp_tx);
    check_eq("abort_opA_kept", opA, 8'h77);
    check_eq("abort_opB_partial", opB, 8'h15);
    tick();
    serial_frame("post_abort", 8'h5A, 8'hC3, 4'h9, 1'b0, 21);
    tick();

    // Back-to-back parallel frames: wrap through zero, then 256 frames total.
    mode = 1'b0; active = 1'b1; aluReady = 1'b1;
    for (int i = 0; i < 2 * (256 - exp_tx); i++) tick();
    check_eq("wrap_zero", txCount, 0);
    for (int i = 0; i < 2 * exp_tx; i++) tick();
    active = 1'b0;
    check_eq("wrap_256", txCount, exp_tx);
    tick();
    check_eq("wrap_idle", busy, 0);

    // Asynchronous reset in the middle of LOAD_A.
    mode = 1'b1; active = 1'b1;
    tick();
    send_bits(8'h05, 3, 1'b0);
    check_eq("areset_pre_opA", opA, 8'h05 | {opA[7:3], 3'b000});
    #2;
    reset = 1'b1;
    #1;
    check_eq("areset_busy", busy, 0);
    check_eq("areset_valid", aluValid, 0);
    check_eq("areset_opA", opA, 0);
    check_eq("areset_opB", opB, 0);
    check_eq("areset_opSel", opSel, 0);
    check_eq("areset_tx", txCount, 0);
    active = 1'b0;
    #5;
    reset = 1'b0;
    tick();
    check_eq("areset_after", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
